// File: rtl/cfa_log_pkg.sv
// Shared definitions for the CFLog writer: FSM state encoding,
// entry geometry and the default log capacity.
package cfa_log_pkg;

    // Writer FSM states.
    typedef enum logic [1:0] {
        CFLOG_IDLE    = 2'd0,
        CFLOG_WR_SRC  = 2'd1,
        CFLOG_WR_DEST = 2'd2,
        CFLOG_FLUSH   = 2'd3
    } cflog_state_t;

    // Each log entry occupies one source word and one destination word.
    localparam int CFLOG_WORDS_PER_ENTRY = 32'd2;

    // Default log capacity in entries.
    localparam int CFLOG_LOG_ENTRIES = 32'd256;

endpackage

// File: rtl/cflog_writer.sv
// CFLog writer: turns each (cflow_src, cflow_dest) record into two 16-bit
// memory writes, collapses runs of loop-counter records into one entry and
// requests a flush from the attestation side once the log is full.
module cflog_writer
    import cfa_log_pkg::*;
#(
    parameter int LOG_ENTRIES = CFLOG_LOG_ENTRIES,
    parameter int ADDR_W      = $clog2(CFLOG_WORDS_PER_ENTRY * LOG_ENTRIES),
    parameter int PTR_W       = $clog2(LOG_ENTRIES) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              log_valid,
    output logic              log_ready,
    input  logic              loop_detect,
    input  logic [15:0]       cflow_src,
    input  logic [15:0]       cflow_dest,
    output logic              log_we,
    output logic [ADDR_W-1:0] log_addr,
    output logic [15:0]       log_wdata,
    output logic [PTR_W-1:0]  log_ptr,
    output logic              flush_req,
    input  logic              flush_ack
);

    // Entry index width: one bit less than the word address.
    localparam int IDX_W = ADDR_W - 1;
    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(LOG_ENTRIES);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    // FSM state
    cflog_state_t state_r;
    cflog_state_t state_nxt_s;

    // Record latched at acceptance
    logic [15:0]      dest_r;
    logic             loop_r;
    logic             append_r;
    logic [IDX_W-1:0] idx_r;

    // Log bookkeeping
    logic             last_loop_r;
    logic [PTR_W-1:0] ptr_r;

    // Registered outputs and their next values
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [15:0]       wdata_r;
    logic              ready_r;
    logic              flush_req_r;
    logic              we_nxt_s;
    logic [ADDR_W-1:0] addr_nxt_s;
    logic [15:0]       wdata_nxt_s;
    logic              ready_nxt_s;
    logic              flush_req_nxt_s;

    // Entry selection and pointer arithmetic
    logic             accept_s;
    logic             overwrite_s;
    logic [IDX_W-1:0] idx_base_s;
    logic [IDX_W-1:0] idx_s;
    logic [PTR_W-1:0] ptr_new_s;
    logic             full_s;
    logic             ack_s;

    // Decide whether the incoming record appends or overwrites the last entry.
    always_comb begin
        accept_s    = (state_r == CFLOG_IDLE) && log_valid;
        overwrite_s = loop_detect && last_loop_r && (ptr_r != {PTR_W{1'b0}});
        // ptr_r < LOG_ENTRIES whenever a record is accepted, so the low bits
        // are the full entry index.
        idx_base_s  = ptr_r[IDX_W-1:0];
        if (overwrite_s) begin
            idx_s = idx_base_s - IDX_ONE;
        end else begin
            idx_s = idx_base_s;
        end
    end

    // Pointer value after the dest write and the resulting full condition.
    always_comb begin
        if (append_r) begin
            ptr_new_s = ptr_r + PTR_ONE;
        end else begin
            ptr_new_s = ptr_r;
        end
        full_s = (ptr_new_s == PTR_FULL);
        ack_s  = (state_r == CFLOG_FLUSH) && flush_ack;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= CFLOG_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            CFLOG_IDLE: begin
                if (log_valid) begin
                    state_nxt_s = CFLOG_WR_SRC;
                end else begin
                    state_nxt_s = CFLOG_IDLE;
                end
            end
            CFLOG_WR_SRC: begin
                state_nxt_s = CFLOG_WR_DEST;
            end
            CFLOG_WR_DEST: begin
                if (full_s) begin
                    state_nxt_s = CFLOG_FLUSH;
                end else begin
                    state_nxt_s = CFLOG_IDLE;
                end
            end
            CFLOG_FLUSH: begin
                if (flush_ack) begin
                    state_nxt_s = CFLOG_IDLE;
                end else begin
                    state_nxt_s = CFLOG_FLUSH;
                end
            end
            default: begin
                state_nxt_s = CFLOG_IDLE;
            end
        endcase
    end

    // FSM output logic: next values for the registered memory-port outputs.
    always_comb begin
        we_nxt_s    = 1'b0;
        addr_nxt_s  = addr_r;
        wdata_nxt_s = wdata_r;
        case (state_r)
            CFLOG_IDLE: begin
                if (log_valid) begin
                    we_nxt_s    = 1'b1;
                    addr_nxt_s  = {idx_s, 1'b0};
                    wdata_nxt_s = cflow_src;
                end else begin
                    we_nxt_s    = 1'b0;
                end
            end
            CFLOG_WR_SRC: begin
                we_nxt_s    = 1'b1;
                addr_nxt_s  = {idx_r, 1'b1};
                wdata_nxt_s = dest_r;
            end
            CFLOG_WR_DEST: begin
                we_nxt_s = 1'b0;
            end
            CFLOG_FLUSH: begin
                we_nxt_s = 1'b0;
            end
            default: begin
                we_nxt_s = 1'b0;
            end
        endcase
        ready_nxt_s     = (state_nxt_s == CFLOG_IDLE);
        flush_req_nxt_s = (state_nxt_s == CFLOG_FLUSH);
    end

    // Output registers, aligned with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_r        <= 1'b0;
            addr_r      <= {ADDR_W{1'b0}};
            wdata_r     <= 16'h0000;
            ready_r     <= 1'b1;
            flush_req_r <= 1'b0;
        end else begin
            we_r        <= we_nxt_s;
            addr_r      <= addr_nxt_s;
            wdata_r     <= wdata_nxt_s;
            ready_r     <= ready_nxt_s;
            flush_req_r <= flush_req_nxt_s;
        end
    end

    // Capture the record and its target entry when it is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dest_r   <= 16'h0000;
            loop_r   <= 1'b0;
            append_r <= 1'b0;
            idx_r    <= {IDX_W{1'b0}};
        end else if (accept_s) begin
            dest_r   <= cflow_dest;
            loop_r   <= loop_detect;
            append_r <= ~overwrite_s;
            idx_r    <= idx_s;
        end else begin
            dest_r   <= dest_r;
            loop_r   <= loop_r;
            append_r <= append_r;
            idx_r    <= idx_r;
        end
    end

    // Commit the entry count and loop history only once the dest word is
    // written, so an aborted write never counts; a flush ack empties the log.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r       <= {PTR_W{1'b0}};
            last_loop_r <= 1'b0;
        end else if (state_r == CFLOG_WR_DEST) begin
            ptr_r       <= ptr_new_s;
            last_loop_r <= loop_r;
        end else if (ack_s) begin
            ptr_r       <= {PTR_W{1'b0}};
            last_loop_r <= 1'b0;
        end else begin
            ptr_r       <= ptr_r;
            last_loop_r <= last_loop_r;
        end
    end

    assign log_we    = we_r;
    assign log_addr  = addr_r;
    assign log_wdata = wdata_r;
    assign log_ready = ready_r;
    assign flush_req = flush_req_r;
    assign log_ptr   = ptr_r;

endmodule
